// File: rtl/uart_rx_ctrl.sv
// Register-mapped controller for the UART receive path: bus registers, shadowed
// baud/parity configuration, a received-byte FIFO with parity flags, and an interrupt.
module uart_rx_ctrl #(
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_perr_i,
   input  logic        rx_busy_i,
   output logic [3:0]  bps_sel_o,
   output logic        check_sel_o,
   output logic        rx_en_o,
   output logic        irq_o
);
   localparam int AW = $clog2(DEPTH);

   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0] level_reg, level_next;
   logic [3:0]    shadow_bps_reg, bps_reg, thresh_reg, thresh_next;
   logic          shadow_chk_reg, chk_reg, rx_en_reg, irq_en_reg, irq_en_next;
   logic          cfg_pending_reg, overrun_reg, overrun_next, perr_reg, perr_next;
   logic          irq_reg, irq_next, ack_reg;
   logic [31:0]   rdata_reg, rd_mux;
   logic          ctrl_wr, stat_wr, flush, data_rd, empty, full;
   logic          push_req, push, pop, ovr_set, apply;
   logic [8:0]    head;
   logic [7:0]    level_ext;

   assign ctrl_wr  = req_i & we_i & (addr_i == 2'd0);
   assign stat_wr  = req_i & we_i & (addr_i == 2'd1);
   assign flush    = req_i & we_i & (addr_i == 2'd3) & wdata_i[0];
   assign data_rd  = req_i & ~we_i & (addr_i == 2'd2);
   assign empty    = (level_reg == '0);
   assign full     = (level_reg == LW'(DEPTH));
   assign head     = mem[rd_ptr_reg];

   // A pop frees the slot that a simultaneous push into a full FIFO needs.
   assign push_req = rx_valid_i & rx_en_reg;
   assign pop      = data_rd & ~empty;
   assign push     = push_req & ~flush & (~full | pop);
   assign ovr_set  = push_req & ~flush & full & ~pop;

   assign level_next   = flush ? '0 : level_reg + LW'(push) - LW'(pop);
   assign overrun_next = ovr_set | (overrun_reg & ~(stat_wr & wdata_i[2]));
   assign perr_next    = (push_req & rx_perr_i) | (perr_reg & ~(stat_wr & wdata_i[3]));
   assign irq_en_next  = ctrl_wr ? wdata_i[6] : irq_en_reg;
   assign thresh_next  = ctrl_wr ? wdata_i[11:8] : thresh_reg;
   assign level_ext    = 8'(level_next);
   assign irq_next     = irq_en_next & (((thresh_next != 4'd0) & (level_ext >= {4'd0, thresh_next}))
                                        | overrun_next | perr_next);

   // The pending configuration reaches the receiver in the very cycle it goes idle.
   assign apply       = cfg_pending_reg & ~rx_busy_i;
   assign bps_sel_o   = apply ? shadow_bps_reg : bps_reg;
   assign check_sel_o = apply ? shadow_chk_reg : chk_reg;
   assign rx_en_o     = rx_en_reg;
   assign irq_o       = irq_reg;
   assign ack_o       = ack_reg;
   assign rdata_o     = rdata_reg;

   always_comb begin
      rd_mux = '0;
      case (addr_i)
         2'd0:    rd_mux = {20'd0, thresh_reg, 1'b0, irq_en_reg, rx_en_reg, shadow_chk_reg, shadow_bps_reg};
         2'd1:    rd_mux = {19'd0, 5'(level_reg), 3'd0, cfg_pending_reg, perr_reg, overrun_reg, full, ~empty};
         2'd2:    rd_mux = empty ? '0 : {23'd0, head};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= {rx_perr_i, rx_data_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         level_reg       <= '0;
         shadow_bps_reg  <= 4'd4;
         bps_reg         <= 4'd4;
         shadow_chk_reg  <= 1'b0;
         chk_reg         <= 1'b0;
         rx_en_reg       <= 1'b1;
         irq_en_reg      <= 1'b0;
         thresh_reg      <= 4'd1;
         cfg_pending_reg <= 1'b0;
         overrun_reg     <= 1'b0;
         perr_reg        <= 1'b0;
         irq_reg         <= 1'b0;
         ack_reg         <= 1'b0;
         rdata_reg       <= '0;
      end else begin
         ack_reg     <= req_i;
         rdata_reg   <= (req_i & ~we_i) ? rd_mux : '0;
         level_reg   <= level_next;
         overrun_reg <= overrun_next;
         perr_reg    <= perr_next;
         irq_en_reg  <= irq_en_next;
         thresh_reg  <= thresh_next;
         irq_reg     <= irq_next;
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (apply) begin
            bps_reg         <= shadow_bps_reg;
            chk_reg         <= shadow_chk_reg;
            cfg_pending_reg <= 1'b0;
         end
         // A new write re-arms the shadow after any copy of the previous value.
         if (ctrl_wr) begin
            shadow_bps_reg  <= wdata_i[3:0];
            shadow_chk_reg  <= wdata_i[4];
            rx_en_reg       <= wdata_i[5];
            cfg_pending_reg <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected bus responses, a monitor
// pops them on ack_o; a queue-based model tracks FIFO, flags, config and interrupt.
module tb_uart_rx_ctrl;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n, req_i, we_i, ack_o, rx_valid_i, rx_perr_i, rx_busy_i;
   logic [1:0]  addr_i;
   logic [31:0] wdata_i, rdata_o;
   logic [7:0]  rx_data_i;
   logic [3:0]  bps_sel_o;
   logic        check_sel_o, rx_en_o, irq_o;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .rx_valid_i(rx_valid_i),
      .rx_data_i(rx_data_i), .rx_perr_i(rx_perr_i), .rx_busy_i(rx_busy_i),
      .bps_sel_o(bps_sel_o), .check_sel_o(check_sel_o), .rx_en_o(rx_en_o), .irq_o(irq_o)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          exp_cyc;
      bit          is_rd;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   // Reference model state
   bit [8:0] mq[$];
   bit       m_ovr, m_per, m_pend, m_rxen, m_irqen, m_irq, m_sh_chk, m_ap_chk;
   int       m_sh_bps, m_ap_bps, m_thr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovr = 0; m_per = 0; m_pend = 0; m_rxen = 1; m_irqen = 0; m_irq = 0;
      m_sh_chk = 0; m_ap_chk = 0; m_sh_bps = 4; m_ap_bps = 4; m_thr = 1;
   endtask

   function automatic logic [31:0] model_read(input int a);
      int n;
      n = mq.size();
      case (a)
         0: return (32'(m_thr) << 8) | (32'(m_irqen) << 6) | (32'(m_rxen) << 5)
                   | (32'(m_sh_chk) << 4) | 32'(m_sh_bps);
         1: return (32'(n) << 8) | (32'(m_pend) << 4) | (32'(m_per) << 3) | (32'(m_ovr) << 2)
                   | (32'(n == DEPTH) << 1) | 32'(n != 0);
         2: return (n != 0) ? 32'(mq[0]) : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // One clock cycle: drive inputs, check live outputs, queue the bus response, advance model.
   task automatic step(input bit rq, input bit w, input int a, input logic [31:0] wd,
                       input bit rv, input logic [7:0] rd, input bit rp, input bit busy);
      bit flush, pop_try, popped, ovr_set, per_set, apply;
      int had;
      req_i = rq; we_i = w; addr_i = 2'(a); wdata_i = wd;
      rx_valid_i = rv; rx_data_i = rd; rx_perr_i = rp; rx_busy_i = busy;
      apply = m_pend && !busy;
      @(negedge clk);
      check("bps_sel_o", 32'(bps_sel_o), apply ? 32'(m_sh_bps) : 32'(m_ap_bps));
      check("check_sel_o", 32'(check_sel_o), apply ? 32'(m_sh_chk) : 32'(m_ap_chk));
      check("rx_en_o", 32'(rx_en_o), 32'(m_rxen));
      check("irq_o", 32'(irq_o), 32'(m_irq));
      if (rq) sb.push_back(exp_t'{cyc + 1, !w, model_read(a)});
      flush   = rq && w && a == 3 && wd[0];
      pop_try = rq && !w && a == 2;
      per_set = rv && m_rxen && rp;
      ovr_set = 0;
      if (flush) mq.delete();
      else begin
         had    = mq.size();
         popped = pop_try && had > 0;
         if (popped) void'(mq.pop_front());
         if (rv && m_rxen) begin
            if (had < DEPTH || popped) mq.push_back({rp, rd});
            else ovr_set = 1;
         end
      end
      if (rq && w && a == 1) begin
         if (wd[2]) m_ovr = 0;
         if (wd[3]) m_per = 0;
      end
      if (ovr_set) m_ovr = 1;
      if (per_set) m_per = 1;
      if (apply) begin
         m_ap_bps = m_sh_bps; m_ap_chk = m_sh_chk; m_pend = 0;
      end
      if (rq && w && a == 0) begin
         m_sh_bps = int'(wd[3:0]); m_sh_chk = wd[4]; m_rxen = wd[5];
         m_irqen = wd[6]; m_thr = int'(wd[11:8]); m_pend = 1;
      end
      m_irq = m_irqen && ((m_thr != 0 && mq.size() >= m_thr) || m_ovr || m_per);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();                      step(0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic push(input logic [7:0] b, input bit p); step(0, 0, 0, 0, 1, b, p, 0); endtask
   task automatic rd(input int a);              step(1, 0, a, 0, 0, 0, 0, 0); endtask
   task automatic wr(input int a, input logic [31:0] d); step(1, 1, a, d, 0, 0, 0, 0); endtask

   // Monitor: compares every acknowledged response with the scoreboard head.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n) begin
         if (ack_o) begin
            if (sb.size() == 0) check("unexpected_ack", 32'(ack_o), 32'd0);
            else begin
               e = sb.pop_front();
               check("ack_cycle", 32'(cyc), 32'(e.exp_cyc));
               if (e.is_rd) check("rdata", rdata_o, e.val);
               $display("txn cyc=%0d %s rdata=0x%08h", cyc, e.is_rd ? "rd" : "wr", rdata_o);
            end
         end else begin
            check("rdata_idle", rdata_o, 32'd0);
            if (sb.size() != 0 && sb[0].exp_cyc <= cyc) begin
               check("missing_ack", 32'(ack_o), 32'd1);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit last_rq;
      int r, op;
      req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0;
      rx_valid_i = 0; rx_data_i = 0; rx_perr_i = 0; rx_busy_i = 0;
      rst_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1;

      // Reset state
      check("rst_bps", 32'(bps_sel_o), 32'd4);
      check("rst_irq", 32'(irq_o), 32'd0);
      rd(1);
      rd(0);

      // Push and pop, including read when empty
      push(8'h55, 0);
      push(8'hA3, 1);
      rd(1);
      rd(2);
      rd(2);
      rd(2);
      rd(1);
      wr(1, 32'h8);

      // Overrun, then push+pop on full, then W1C
      for (int i = 0; i < 17; i++) push(8'(i + 8'h10), 0);
      rd(1);
      step(1, 0, 2, 0, 1, 8'h77, 0, 0);
      rd(1);
      wr(1, 32'h4);
      rd(1);
      wr(3, 32'h1);
      rd(1);

      // Config shadow held off by busy receiver
      step(1, 1, 0, 32'h136, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      idle();
      idle();
      rd(1);

      // Threshold interrupt
      wr(0, 32'h364);
      for (int i = 0; i < 3; i++) push(8'(8'hC0 + i), 0);
      idle();
      rd(2);
      idle();
      idle();

      // Flush racing a push; push+pop on empty
      push(8'h11, 0);
      step(1, 1, 3, 32'h1, 1, 8'h99, 0, 0);
      rd(1);
      step(1, 0, 2, 0, 1, 8'h5A, 0, 0);
      rd(1);
      rd(2);

      // Receiver disabled, then perr set racing its W1C
      wr(0, 32'h144);
      push(8'h33, 1);
      rd(1);
      wr(0, 32'h164);
      step(1, 1, 1, 32'h8, 1, 8'h44, 1, 0);
      rd(1);
      wr(1, 32'hC);
      wr(3, 32'h1);

      // Randomized traffic
      last_rq = 0;
      for (int i = 0; i < 800; i++) begin
         bit rq, w, rv, rp, busy;
         int a;
         logic [31:0] wd;
         r = int'($urandom_range(0, 99));
         rv = (r < 45);
         rp = ($urandom_range(0, 9) == 0);
         busy = ($urandom_range(0, 1) == 1);
         rq = !last_rq && ($urandom_range(0, 99) < 45);
         w = 0; a = 0; wd = 0;
         if (rq) begin
            op = int'($urandom_range(0, 99));
            if (op < 35)      begin w = 0; a = 2; end
            else if (op < 55) begin w = 0; a = 1; end
            else if (op < 62) begin w = 0; a = int'($urandom_range(0, 3)); end
            else if (op < 77) begin w = 1; a = 1; wd = $urandom; end
            else if (op < 92) begin
               w = 1; a = 0;
               wd = {20'd0, 4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 6))};
            end else begin w = 1; a = 3; wd = 32'($urandom_range(0, 1)); end
         end
         step(rq, w, a, wd, rv, 8'($urandom), rp, busy);
         last_rq = rq;
      end
      idle();
      idle();

      // Async reset mid-cycle with a request in flight
      wr(0, 32'h0000_0176);
      push(8'hEE, 1);
      idle();
      req_i = 1; we_i = 0; addr_i = 2'd1;
      #2;
      rst_n = 0;
      req_i = 0;
      #1;
      check("arst_bps", 32'(bps_sel_o), 32'd4);
      check("arst_chk", 32'(check_sel_o), 32'd0);
      check("arst_rxen", 32'(rx_en_o), 32'd1);
      check("arst_irq", 32'(irq_o), 32'd0);
      check("arst_ack", 32'(ack_o), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check("arst_no_ack", 32'(ack_o), 32'd0);
      rst_n = 1;
      @(posedge clk);
      #1;
      rd(1);
      rd(0);
      idle();
      idle();

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
